// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue
//   Halfword instruction queue between the instruction memory port and the
//   Thumb-2 pre-decoder. Accepts FETCH_HW (1 or 2) halfwords per fetch beat
//   into a circular store of DEPTH halfwords. Presents one assembled 16- or
//   32-bit instruction per cycle with valid/ready backpressure.
//
// Parameters
//   FETCH_HW    halfwords per fetch beat (1 or 2)
//   DEPTH       halfword entries (power of two, >= 4)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   fetch_data  fetch beat, [15:0] is the oldest halfword
//   fetch_valid beat present
//   fetch_ready queue has room for a full beat (from current count only)
//   flush       discard all queued halfwords; overrides push and pop
//   flush_odd   with flush: drop [15:0] of the first beat after the flush
//   inst        head instruction: {hw0, hw1} if 32-bit, else {16'h0, hw0}
//   inst_is32   head is a 32-bit encoding
//   inst_valid  a complete instruction is at the head
//   inst_ready  decode consumes the head
//   count       occupied halfword entries
module thumb_fetch_queue #(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*FETCH_HW-1:0]   fetch_data,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     flush_odd,
  output logic [31:0]              inst,
  output logic                     inst_is32,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_BEAT  = CW'(FETCH_HW);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic          skip_lo;

  logic [15:0]   head_hw;
  logic [15:0]   next_hw;
  logic          head_is32;
  logic          push;
  logic          pop;
  logic [CW-1:0] free_n;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Second halfword of a 32-bit instruction may sit at entry 0 when the
  // head is at DEPTH-1; the AW-bit add wraps naturally.
  assign rd_ptr_nx = rd_ptr + PTR_ONE;
  assign head_hw   = mem[rd_ptr];
  assign next_hw   = mem[rd_ptr_nx];
  assign head_is32 = (head_hw[15:11] == 5'b11101) ||
                     (head_hw[15:11] == 5'b11110) ||
                     (head_hw[15:11] == 5'b11111);

  always_comb begin
    inst       = '0;
    inst_is32  = 1'b0;
    inst_valid = (count != '0) && (!head_is32 || (count >= CNT_TWO));
    if (inst_valid) begin
      inst_is32 = head_is32;
      inst      = head_is32 ? {head_hw, next_hw} : {16'h0000, head_hw};
    end

    free_n      = CNT_DEPTH - count;
    fetch_ready = (free_n >= CNT_BEAT);

    // Flush wins over both handshakes.
    push = fetch_valid && fetch_ready && !flush;
    pop  = inst_valid && inst_ready && !flush;

    push_n = '0;
    if (push) begin
      push_n = skip_lo ? CNT_ONE : CNT_BEAT;
    end

    pop_n = '0;
    if (pop) begin
      pop_n = head_is32 ? CNT_TWO : CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      skip_lo <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      skip_lo <= flush_odd && (FETCH_HW == 2);
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + push_n[AW-1:0];
        skip_lo <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + pop_n[AW-1:0];
      end
      count <= count + push_n - pop_n;
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  // skip_lo is only ever set when FETCH_HW == 2, so the top halfword of the
  // beat is the one kept.
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip_lo) begin
        mem[wr_ptr] <= fetch_data[16*(FETCH_HW-1) +: 16];
      end else begin
        for (int unsigned i = 0; i < FETCH_HW; i++) begin
          mem[wr_ptr + AW'(i)] <= fetch_data[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: doc/thumb_fetch_queue.md
# thumb_fetch_queue

Parametrised halfword instruction queue between the instruction memory port and the pre-decoder of the Thumb-2 core. It accepts 1 or 2 halfwords per fetch beat, buffers them in a circular halfword store, and presents one assembled 16- or 32-bit Thumb instruction per cycle to decode with valid/ready backpressure. It adds multi-halfword fetch, branch flush and halfword-aligned branch-target entry to the core's single-halfword fetch stage.

## Interface
- FETCH_HW, 2, halfwords per fetch beat; legal values 1 or 2.
- DEPTH, 8, halfword entries; power of two, minimum 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_data  in  16*FETCH_HW  fetch beat; bits [15:0] hold the oldest halfword.
- fetch_valid  in  1  beat present.
- fetch_ready  out  1  queue can accept a full beat.
- flush  in  1  discard all queued halfwords (branch taken).
- flush_odd  in  1  sampled with flush; the first beat after the flush drops its [15:0] halfword. Ignored when FETCH_HW=1.
- inst  out  32  head instruction. A 32-bit instruction is {first_hw, second_hw}. A 16-bit instruction is {16'h0, hw}.
- inst_is32  out  1  head is a 32-bit encoding.
- inst_valid  out  1  a complete instruction is at the head.
- inst_ready  in  1  decode consumes the head.
- count  out  $clog2(DEPTH)+1  occupied halfword entries.

## Operation
- State:
  - Halfword array mem[DEPTH].
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count.
  - skip_lo flag.
- 32-bit detect: the head halfword has [15:11] equal to 5'b11101, 5'b11110 or 5'b11111.
- inst_valid = (count≥1) and (!is32 or count≥2). When inst_valid=0, inst and inst_is32 are driven 0.
- fetch_ready = (DEPTH − count ≥ FETCH_HW). It is computed from the current count only; a same-cycle pop does not raise it.
- Push occurs when fetch_valid and fetch_ready:
  - Halfwords are written at wr_ptr, wr_ptr+1, … in age order.
  - If skip_lo=1, halfword [15:0] is dropped, only [31:16] is written, the push adds 1 to count, and skip_lo clears.
  - Otherwise the push adds FETCH_HW to count.
- Pop occurs when inst_valid and inst_ready. rd_ptr and count advance by 1 for a 16-bit instruction, or by 2 for a 32-bit instruction.
- Simultaneous push and pop: count_next = count + pushed − popped. Both pointers update independently.
- Flush is synchronous and has highest priority. When flush=1:
  - rd_ptr, wr_ptr and count are set to 0.
  - skip_lo is set to flush_odd & (FETCH_HW==2).
  - Any same-cycle push or pop is discarded. A pop has no effect even though decode sees the handshake.
- Pointers wrap from DEPTH−1 to 0. A 32-bit instruction may straddle the wrap, with the first halfword at DEPTH−1 and the second at 0.
- mem contents are not reset. Only pointers, count and skip_lo are reset.

## Timing
- Reset (rst=0, asynchronous) forces:
  - count=0, rd_ptr=0, wr_ptr=0, skip_lo=0.
  - Therefore inst_valid=0, inst=0, inst_is32=0, and fetch_ready=1.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Latency: a halfword pushed at edge N is visible on inst at cycle N+1 (combinational read of the head). A 32-bit instruction becomes valid the cycle after its second halfword is written.
- inst, inst_is32 and inst_valid are combinational from registered state only. They have no combinational path from fetch_data, fetch_valid, inst_ready or flush.
- Throughput is one instruction per cycle regardless of instruction size, provided the queue is fed.
- Full: when DEPTH − count < FETCH_HW, fetch_ready=0. A beat presented with fetch_valid=1 is not written, and the source must hold it.
- Empty, or a lone first half of a 32-bit instruction at the head: inst_valid=0, and inst_ready is ignored.

## Test plan
- FETCH_HW=1, DEPTH=8: push 0x4608, 0xF000, 0xF800 on consecutive cycles with inst_ready=1 → inst=0x00004608, is32=0 in cycle 1; inst=0xF000F800, is32=1 in cycle 3 only; count returns to 0.
- FETCH_HW=2, DEPTH=8, straddle: push beat 0xF7FF_2001, then beat 0x4770_FFFE → outputs in order 0x00002001, 0xF7FFFFFE (is32=1), 0x00004770.
- Full and backpressure: inst_ready=0 and push 4 beats → count=8, fetch_ready=0; a 5th beat is held and not written. Then pop a 16-bit instruction → count=7, fetch_ready stays 0 while DEPTH − count < 2.
- Wrap: DEPTH=4, FETCH_HW=1; cycle entries until rd_ptr=3, then push 0xE92D (rd_ptr=3) followed by 0x4FF0 → inst=0xE92D4FF0 read across the wrap.
- Flush: queue holds 3 halfwords; assert flush=1 and flush_odd=1 together with fetch_valid=1 and inst_valid/inst_ready handshake → next cycle count=0, nothing pushed or popped. Then push beat 0x4770_BF00 → only 0x00004770 is delivered, and count goes 0→1.
- Async reset: assert rst=0 between clock edges with count=5 → count=0 and inst_valid=0 immediately; after release, fetch_ready=1 and the first push appears on inst one cycle later.
